// File: rtl/seq_signed_multiplier_pkg.sv
// Shared definitions for the sequential signed multiplier: default operand
// width, counter width and the controller state encoding.
package seq_signed_multiplier_pkg;

    localparam int WIDTH_DEFAULT = 8;
    localparam int CNT_WIDTH     = $clog2(WIDTH_DEFAULT + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINISH
    } stateType;

endpackage

// File: rtl/seq_signed_multiplier_complementer.sv
// Two's-complement negation stage; the multiplier uses one per operand to
// form magnitudes from negative inputs.
module seq_signed_multiplier_complementer
    import seq_signed_multiplier_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] negated
);

    assign negated = ~value + WIDTH'(1);

endmodule

// File: rtl/seq_signed_multiplier.sv
// Sequential signed shift-and-add multiplier: multiplies operand magnitudes
// over WIDTH cycles, then restores the sign of the 2*WIDTH-bit product.
module seq_signed_multiplier
    import seq_signed_multiplier_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multA,
    input  logic [WIDTH-1:0]     multB,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH;

    stateType          state;
    logic [WIDTH-1:0]  negA;
    logic [WIDTH-1:0]  negB;
    logic [WIDTH-1:0]  magAIn;
    logic [WIDTH-1:0]  magBIn;
    logic [WIDTH-1:0]  magB;
    logic [PW-1:0]     mcand;
    logic [PW-1:0]     acc;
    logic [CW-1:0]     cnt;
    logic              negRes;

    seq_signed_multiplier_complementer #(.WIDTH(WIDTH)) uNegA (
        .value   (multA),
        .negated (negA)
    );

    seq_signed_multiplier_complementer #(.WIDTH(WIDTH)) uNegB (
        .value   (multB),
        .negated (negB)
    );

    // -128 negates to 0x80, which is the correct unsigned magnitude.
    assign magAIn = multA[WIDTH-1] ? negA : multA;
    assign magBIn = multB[WIDTH-1] ? negB : multB;

    // The multiplicand is kept in a shifting register so each CALC step
    // adds it unshifted instead of shifting by the counter value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            mcand   <= '0;
            magB    <= '0;
            acc     <= '0;
            cnt     <= '0;
            negRes  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, magAIn};
                        magB   <= magBIn;
                        negRes <= multA[WIDTH-1] ^ multB[WIDTH-1];
                        acc    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (magB[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand <= mcand << 1;
                    magB  <= magB >> 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    product <= negRes ? (~acc + PW'(1)) : acc;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_signed_multiplier.md
Name: seq_signed_multiplier

Overview:
Sequential 8x8 signed (two's-complement) shift-and-add multiplier built around the team's 8-bit two's-complement negation stage.
- Operands are converted to magnitudes, multiplied over WIDTH cycles, and the 16-bit result is re-negated when the operand signs differ.
- Sits between the operand source and the result consumer.
- Start/done handshake; one product in flight at a time.

Parameters:
WIDTH, 8, operand width in bits; product is 2*WIDTH and iteration count is WIDTH.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only when idle
multA  input  WIDTH  signed multiplicand, captured on accepted start
multB  input  WIDTH  signed multiplier, captured on accepted start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when product is valid
product  output  2*WIDTH  signed result; holds until next done

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset, on a clk edge with rst=1:
  - state=IDLE; busy=0, done=0, product=0; counter, accumulator and operand registers cleared.
  - rst has priority over everything, including mid-operation.
  - Reset mid-operation aborts the operation with no done pulse, and product reads 0.
- State machine: IDLE, CALC, FINISH.
  - IDLE:
    - On an edge with start=1, capture magA=|multA|, magB=|multB| via two's-complement negation when the MSB is set.
    - Capture negRes = multA[MSB] XOR multB[MSB]; clear acc (2*WIDTH bits) and cnt.
    - Go to CALC; busy=1 from this edge.
  - CALC, one edge per bit:
    - If magB[0], acc += magA zero-extended and shifted left by cnt (equivalently a shifting multiplicand register).
    - Then magB >>= 1, cnt += 1.
    - After the WIDTH-th CALC edge, go to FINISH.
  - FINISH, one edge:
    - product <= negRes ? (~acc + 1) : acc, in 2*WIDTH-bit wrap arithmetic; done=1; busy=0; state=IDLE.
- Magnitudes are unsigned WIDTH bits: -128 maps to magnitude 128 (0x80), which is correct as unsigned. No overflow is possible: the worst case is (-128)*(-128)=+16384, which fits.
- Latency, for start sampled at edge E0:
  - CALC on E1..E8; FINISH at E9.
  - done=1 and product valid in the cycle after E9, i.e. 9 edges from acceptance.
  - busy=1 during the cycles following E0..E8.
- done is a single-cycle pulse and deasserts on the next edge.
- start while busy=1 is ignored: no queuing, and inputs are not re-captured.
- start may be high in the cycle done=1 (state is IDLE). It is accepted at that edge and produces back-to-back operations with 10-edge throughput.
- multA and multB may change freely after the accepting edge.
- A zero result with negRes=1 negates to 0; the output is 0x0000, never a distinct -0.
- product is unchanged between done pulses.

Decomposition:
- Shared package holds:
  - WIDTH default.
  - State encoding typedef (IDLE/CALC/FINISH).
  - Counter width constant $clog2(WIDTH+1).
- Natural sub-module: the existing complementer, instantiated twice for the operand magnitudes (selected by sign bit).
- The 2*WIDTH result negation is inline (~acc+1). No other sub-modules.

Test Plan:
- 7 * -3 (multA=0x07, multB=0xFD), start pulse -> busy 9 cycles, then done pulse with product=0xFFEB (-21).
- -128 * -128 (0x80, 0x80) -> product=0x4000; and -128 * 127 (0x80, 0x7F) -> product=0xC080 (-16256).
- 0 * -5 (0x00, 0xFB) -> product=0x0000; 127 * 127 -> product=0x3F01.
- 5*6 started, then start with 2*2 at the 3rd busy cycle -> the second start is ignored; single done with product=0x001E, no further done.
- Back-to-back: start held high through the done cycle with new operands -5*5 -> first done 0x001E, second done 10 edges later with 0xFFE7.
- rst=1 at the 4th CALC cycle of 9*9 -> the next cycle has busy=0, done=0, product=0, and no done ever appears; the next start of 3*3 yields 0x0009.
